// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if : requester-side bus of the shared SRAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic                host_lock;
  logic                clr_err;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic                drop_err;

  modport slave (
    input  req, we, addr, wdata, host_lock, clr_err,
    output ack, rdata, busy, drop_err
  );

  modport master (
    output req, we, addr, wdata, host_lock, clr_err,
    input  ack, rdata, busy, drop_err
  );
endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter : round-robin arbiter sharing one single-port SRAM among
//                     host, fetch and drain requesters (one word per grant)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  wire logic              clk,
  input  wire logic              n_rst,
  sram_port_arbiter_if.slave     bus,
  output logic                   sram_en,
  output logic                   sram_we,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  input  wire logic [DATA_W-1:0] sram_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] gsel_q, gsel_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       drop_err_q, drop_err_d;

  logic [2:0]        elig;
  logic [1:0]        cand0, cand1, cand2, pick;
  logic              sel_req, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        ack_v;
  logic [DATA_W-1:0] rdata_v;
  logic              busy_v;

  function automatic logic [1:0] next_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search order starts just after the last granted requester
  always_comb begin
    elig  = bus.host_lock ? {2'b00, bus.req[0]} : bus.req;
    cand0 = next_idx(rr_ptr_q);
    cand1 = next_idx(cand0);
    cand2 = next_idx(cand1);
    if (elig[cand0])      pick = cand0;
    else if (elig[cand1]) pick = cand1;
    else                  pick = cand2;
  end

  always_comb begin
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (gsel_q)
      2'd0: begin
        sel_req   = bus.req[0];
        sel_we    = bus.we[0];
        sel_addr  = bus.addr[0 +: ADDR_W];
        sel_wdata = bus.wdata[0 +: DATA_W];
      end
      2'd1: begin
        sel_req   = bus.req[1];
        sel_we    = bus.we[1];
        sel_addr  = bus.addr[ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_req   = bus.req[2];
        sel_we    = bus.we[2];
        sel_addr  = bus.addr[2*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    gsel_d     = gsel_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    ack_v      = 3'b000;
    rdata_v    = '0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          gsel_d  = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sram_en    = 1'b1;
        sram_we    = sel_we;
        sram_addr  = sel_addr;
        sram_wdata = sel_wdata;
        if (sel_we) begin
          ack_v    = 3'b001 << gsel_q;
          rr_ptr_d = gsel_q;
          state_d  = S_IDLE;
        end else begin
          cnt_d   = 2'(RD_LAT);
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          ack_v    = 3'b001 << gsel_q;
          rdata_v  = sram_rdata;
          rr_ptr_d = gsel_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_v = (state_q != S_IDLE);

  // A vanishing request is flagged but the access still runs to completion
  assign drop_err_d = (busy_v && !sel_req) || (drop_err_q && !bus.clr_err);

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q    <= S_IDLE;
      gsel_q     <= 2'd0;
      rr_ptr_q   <= 2'd2;
      cnt_q      <= 2'd0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gsel_q     <= gsel_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign bus.ack      = ack_v;
  assign bus.rdata    = rdata_v;
  assign bus.busy     = busy_v;
  assign bus.drop_err = drop_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter : directed-vector bench for sram_port_arbiter (RD_LAT=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_port_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int LAT = 2;

  localparam logic [63:0] D_HOST  = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] D_FETCH = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] D_DRAIN = 64'hCCCC_0000_0000_0003;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int vecs = 0;
  int errs = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model with LAT cycles of read latency
  logic [DW-1:0] mem  [1024];
  logic [DW-1:0] pipe [LAT];

  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_we) pipe[0] <= mem[sram_addr];
    else                     pipe[0] <= '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign sram_rdata = pipe[LAT-1];

  // Grant pattern with all three requesters writing continuously, rr starting at fetch
  logic [2:0]    exp_ack  [12] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b010,
                                   3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b010};
  logic [AW-1:0] exp_addr [12] = '{10'h000, 10'h300, 10'h000, 10'h100, 10'h000, 10'h200,
                                   10'h000, 10'h300, 10'h000, 10'h100, 10'h000, 10'h200};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req       = 3'b000;
    bus.we        = 3'b000;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.host_lock = 1'b0;
    bus.clr_err   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_ack",      64'(bus.ack),      64'd0);
    chk("rst_rdata",    bus.rdata,         64'd0);
    chk("rst_drop_err", 64'(bus.drop_err), 64'd0);
    chk("rst_sram_en",  64'(sram_en),      64'd0);
    chk("rst_sram_we",  64'(sram_we),      64'd0);
    chk("rst_addr",     64'(sram_addr),    64'd0);
    chk("rst_wdata",    sram_wdata,        64'd0);
    @(negedge clk); n_rst = 1'b0;

    // Host write to 0x005
    @(negedge clk);
    bus.req = 3'b001; bus.we = 3'b001;
    bus.addr[0 +: AW] = 10'h005; bus.wdata[0 +: DW] = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("t1_c0_busy", 64'(bus.busy), 64'd0);
    chk("t1_c0_ack",  64'(bus.ack),  64'd0);
    @(negedge clk); #1;
    chk("t1_c1_en",    64'(sram_en),   64'd1);
    chk("t1_c1_we",    64'(sram_we),   64'd1);
    chk("t1_c1_addr",  64'(sram_addr), 64'h005);
    chk("t1_c1_wdata", sram_wdata,     64'hDEAD_BEEF_0000_0001);
    chk("t1_c1_ack",   64'(bus.ack),   64'b001);
    chk("t1_c1_busy",  64'(bus.busy),  64'd1);
    @(negedge clk); bus.req = 3'b000; #1;
    chk("t1_c2_busy", 64'(bus.busy), 64'd0);
    chk("t1_c2_ack",  64'(bus.ack),  64'd0);
    chk("t1_c2_en",   64'(sram_en),  64'd0);

    // Host writes the word the fetch read will return
    @(negedge clk);
    bus.req = 3'b001; bus.we = 3'b001;
    bus.addr[0 +: AW] = 10'h010; bus.wdata[0 +: DW] = 64'h1122_3344_5566_7788;
    @(negedge clk); #1;
    chk("pre_ack",  64'(bus.ack),   64'b001);
    chk("pre_addr", 64'(sram_addr), 64'h010);
    @(negedge clk); bus.req = 3'b000; bus.we = 3'b000;

    // Fetch read from 0x010, ack at cycle 1+RD_LAT
    @(negedge clk);
    bus.req = 3'b010; bus.we = 3'b000; bus.addr[AW +: AW] = 10'h010;
    #1;
    chk("t2_c0_ack",   64'(bus.ack), 64'd0);
    chk("t2_c0_rdata", bus.rdata,    64'd0);
    @(negedge clk); #1;
    chk("t2_c1_en",    64'(sram_en),   64'd1);
    chk("t2_c1_we",    64'(sram_we),   64'd0);
    chk("t2_c1_addr",  64'(sram_addr), 64'h010);
    chk("t2_c1_ack",   64'(bus.ack),   64'd0);
    chk("t2_c1_rdata", bus.rdata,      64'd0);
    @(negedge clk); #1;
    chk("t2_c2_ack",   64'(bus.ack),  64'd0);
    chk("t2_c2_rdata", bus.rdata,     64'd0);
    chk("t2_c2_busy",  64'(bus.busy), 64'd1);
    @(negedge clk); #1;
    chk("t2_c3_ack",   64'(bus.ack), 64'b010);
    chk("t2_c3_rdata", bus.rdata,    64'h1122_3344_5566_7788);
    @(negedge clk); bus.req = 3'b000; #1;
    chk("t2_c4_ack",   64'(bus.ack),  64'd0);
    chk("t2_c4_rdata", bus.rdata,     64'd0);
    chk("t2_c4_busy",  64'(bus.busy), 64'd0);

    // All three requesters write continuously; last grant was fetch
    @(negedge clk);
    bus.req = 3'b111; bus.we = 3'b111;
    bus.addr  = {10'h300, 10'h200, 10'h100};
    bus.wdata = {D_DRAIN, D_FETCH, D_HOST};
    for (int k = 0; k < 12; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk($sformatf("t3_ack_%0d", k),  64'(bus.ack),   64'(exp_ack[k]));
      chk($sformatf("t3_addr_%0d", k), 64'(sram_addr), 64'(exp_addr[k]));
    end

    // host_lock with all requesting reads; lock released mid-read
    @(negedge clk);
    bus.host_lock = 1'b1; bus.we = 3'b000; #1;
    chk("t4_l0_busy", 64'(bus.busy), 64'd0);
    @(negedge clk); #1;
    chk("t4_l1_addr", 64'(sram_addr), 64'h100);
    chk("t4_l1_ack",  64'(bus.ack),   64'd0);
    @(negedge clk); bus.host_lock = 1'b0; #1;
    chk("t4_l2_ack",  64'(bus.ack),  64'd0);
    chk("t4_l2_busy", 64'(bus.busy), 64'd1);
    @(negedge clk); #1;
    chk("t4_l3_ack",   64'(bus.ack), 64'b001);
    chk("t4_l3_rdata", bus.rdata,    D_HOST);
    @(negedge clk); #1;
    chk("t4_l4_busy", 64'(bus.busy), 64'd0);
    @(negedge clk); #1;
    chk("t4_l5_addr", 64'(sram_addr), 64'h200);
    chk("t4_l5_ack",  64'(bus.ack),   64'd0);

    // Fetch abandons its read during RD_WAIT
    @(negedge clk); bus.req = 3'b000; #1;
    chk("t5_l6_drop", 64'(bus.drop_err), 64'd0);
    chk("t5_l6_ack",  64'(bus.ack),      64'd0);
    @(negedge clk); #1;
    chk("t5_l7_drop",  64'(bus.drop_err), 64'd1);
    chk("t5_l7_ack",   64'(bus.ack),      64'b010);
    chk("t5_l7_rdata", bus.rdata,         D_FETCH);
    @(negedge clk); #1;
    chk("t5_l8_drop", 64'(bus.drop_err), 64'd1);
    chk("t5_l8_busy", 64'(bus.busy),     64'd0);
    @(negedge clk); bus.clr_err = 1'b1; #1;
    chk("t5_l9_drop", 64'(bus.drop_err), 64'd1);
    @(negedge clk); bus.clr_err = 1'b0; #1;
    chk("t5_l10_drop", 64'(bus.drop_err), 64'd0);

    // Reset during RD_WAIT, drain pending across reset
    @(negedge clk);
    bus.req = 3'b010; bus.we = 3'b000; bus.addr[AW +: AW] = 10'h200;
    @(negedge clk); #1;
    chk("t6_r1_en", 64'(sram_en), 64'd1);
    @(negedge clk);
    n_rst = 1'b1; bus.req = 3'b100; bus.we = 3'b100; #1;
    chk("t6_r2_busy", 64'(bus.busy), 64'd0);
    chk("t6_r2_ack",  64'(bus.ack),  64'd0);
    chk("t6_r2_en",   64'(sram_en),  64'd0);
    @(negedge clk); #1;
    chk("t6_r3_ack",   64'(bus.ack), 64'd0);
    chk("t6_r3_rdata", bus.rdata,    64'd0);
    n_rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_r4_ack",   64'(bus.ack),   64'b100);
    chk("t6_r4_addr",  64'(sram_addr), 64'h300);
    chk("t6_r4_we",    64'(sram_we),   64'd1);
    chk("t6_r4_wdata", sram_wdata,     D_DRAIN);
    @(negedge clk); bus.req = 3'b000; #1;
    chk("t6_r5_busy", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
